// File: rtl/aes_spi_sequencer_pkg.sv
// Shared types and constants for the AES-over-SPI sequencer.
package aes_spi_pkg;

  localparam int unsigned FRAME_W = 392;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned KEY_W   = 256;
  localparam int unsigned SIZE_W  = 8;
  localparam int unsigned WD_W    = 16;
  localparam int unsigned XFER_W  = 8;

  // Result block position inside the received frame
  localparam int unsigned RES_LSB = 256;

  localparam logic [SIZE_W-1:0] SIZE_128 = 8'd16;
  localparam logic [SIZE_W-1:0] SIZE_192 = 8'd24;
  localparam logic [SIZE_W-1:0] SIZE_256 = 8'd32;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_KEY     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_RESP
  } state_e;

  // Send frame: block in [391:264], key size in [263:256], key in [255:0]
  typedef struct packed {
    logic [BLOCK_W-1:0] block;
    logic [SIZE_W-1:0]  key_size;
    logic [KEY_W-1:0]   key;
  } send_frame_t;

  function automatic logic key_size_ok(input logic [SIZE_W-1:0] size);
    return (size == SIZE_128) || (size == SIZE_192) || (size == SIZE_256);
  endfunction

endpackage

// File: rtl/aes_spi_sequencer_if.sv
// Request/response handshake between the request source and the sequencer.
interface aes_spi_sequencer_if;
  import aes_spi_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_decrypt;
  logic [BLOCK_W-1:0] req_block;
  logic [KEY_W-1:0]   req_key;
  logic [SIZE_W-1:0]  req_key_size;
  logic               resp_valid;
  logic               resp_ready;
  logic [BLOCK_W-1:0] resp_block;
  logic [1:0]         resp_err;

  modport master (
    output req_valid, req_decrypt, req_block, req_key, req_key_size, resp_ready,
    input  req_ready, resp_valid, resp_block, resp_err
  );

  modport slave (
    input  req_valid, req_decrypt, req_block, req_key, req_key_size, resp_ready,
    output req_ready, resp_valid, resp_block, resp_err
  );

endinterface

// File: rtl/aes_spi_sequencer_watchdog.sv
// Per-transfer watchdog: counts cycles since the last clear and flags TIMEOUT.
module aes_seq_watchdog
  import aes_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic expired_o
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;
  logic            expired_q;

  // Counter restarts from zero while cleared, otherwise counts up
  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q + WD_W'(1);
  end

  // Expiry is registered so it is high in the cycle the count sits at TIMEOUT-1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= !clear_i && (cnt_d == LAST);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/aes_spi_sequencer.sv
// Runs one AES operation over the SPI master: send, poll transfers, receive.
module aes_spi_sequencer
  import aes_spi_pkg::*;
#(
  parameter int unsigned ENC_WAIT = 1,
  parameter int unsigned DEC_WAIT = 2,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic               clk,
  input  logic               reset,
  aes_spi_sequencer_if.slave req_if,
  output logic               m_start,
  input  logic               m_busy,
  input  logic               m_done,
  output logic [FRAME_W-1:0] m_data_in,
  input  logic [FRAME_W-1:0] m_data_out,
  output logic               busy
);

  localparam logic [XFER_W-1:0] ENC_XFERS = XFER_W'(2 + ENC_WAIT);
  localparam logic [XFER_W-1:0] DEC_XFERS = XFER_W'(2 + DEC_WAIT);

  state_e             state_q, state_d;
  logic               dec_q, dec_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [XFER_W-1:0]  xfer_q, xfer_d;
  logic [FRAME_W-1:0] m_data_in_q, m_data_in_d;
  logic [BLOCK_W-1:0] resp_block_q, resp_block_d;
  logic [1:0]         resp_err_q, resp_err_d;
  logic               resp_valid_q, resp_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               m_start_q, m_start_d;
  logic               busy_q, busy_d;
  logic               wd_clear, wd_expired;
  logic               unused_frame_bits;

  // Only the result block of the received frame is meaningful
  assign unused_frame_bits = ^{m_data_out[FRAME_W-1:RES_LSB+BLOCK_W], m_data_out[RES_LSB-1:0]};

  // Watchdog runs from the start pulse through the whole WAIT state
  assign wd_clear = (state_q != S_WAIT) && !m_start_q;

  aes_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (wd_clear),
    .expired_o(wd_expired)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dec_q        <= 1'b0;
      block_q      <= '0;
      key_q        <= '0;
      size_q       <= '0;
      xfer_q       <= '0;
      m_data_in_q  <= '0;
      resp_block_q <= '0;
      resp_err_q   <= ERR_OK;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      m_start_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_q        <= dec_d;
      block_q      <= block_d;
      key_q        <= key_d;
      size_q       <= size_d;
      xfer_q       <= xfer_d;
      m_data_in_q  <= m_data_in_d;
      resp_block_q <= resp_block_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      m_start_q    <= m_start_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    dec_d        = dec_q;
    block_d      = block_q;
    key_d        = key_q;
    size_d       = size_q;
    xfer_d       = xfer_q;
    m_data_in_d  = m_data_in_q;
    resp_block_d = resp_block_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_if.req_valid && req_ready_q) begin
          dec_d   = req_if.req_decrypt;
          block_d = req_if.req_block;
          key_d   = req_if.req_key;
          size_d  = req_if.req_key_size;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!key_size_ok(size_q)) begin
          resp_err_d   = ERR_KEY;
          resp_block_d = '0;
          state_d      = S_RESP;
        end else begin
          m_data_in_d = send_frame_t'{block: block_q, key_size: size_q, key: key_q};
          xfer_d      = '0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (m_start_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_done) begin
          state_d = S_NEXT;
        end else if (wd_expired) begin
          resp_err_d = ERR_TIMEOUT;
          state_d    = S_RESP;
        end
      end
      S_NEXT: begin
        xfer_d = xfer_q + XFER_W'(1);
        if (xfer_d == (dec_q ? DEC_XFERS : ENC_XFERS)) begin
          resp_block_d = m_data_out[RES_LSB +: BLOCK_W];
          resp_err_d   = ERR_OK;
          state_d      = S_RESP;
        end else begin
          m_data_in_d = '0;
          state_d     = S_LAUNCH;
        end
      end
      S_RESP: begin
        if (req_if.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Start fires on entry to LAUNCH (or while parked there) once the master is idle
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    m_start_d    = (state_d == S_LAUNCH) && !m_busy;
  end

  assign req_if.req_ready  = req_ready_q;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_block = resp_block_q;
  assign req_if.resp_err   = resp_err_q;
  assign m_start           = m_start_q;
  assign m_data_in         = m_data_in_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Directed bench for aes_spi_sequencer with a behavioural SPI master + AES slave.
module tb_aes_spi_sequencer;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY24 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY16 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY32 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    string        name;
    logic         dec;
    logic [127:0] block;
    logic [255:0] key;
    logic [7:0]   size;
    logic [127:0] exp_block;
    logic [1:0]   exp_err;
    int           exp_starts;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         m_start;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [391:0] m_data_in;
  logic [391:0] m_data_out = '0;
  logic         busy;

  aes_spi_sequencer_if bus ();

  aes_spi_sequencer #(.ENC_WAIT(1), .DEC_WAIT(2), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_if    (bus),
    .m_start   (m_start),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_data_in (m_data_in),
    .m_data_out(m_data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           start_cnt = 0;
  int           last_start_cyc = 0;
  int           last_done_cyc = 0;
  int           mdl_cnt = 0;
  bit           mdl_en = 1'b1;
  logic [127:0] mdl_blk = '0;
  logic [391:0] frame_log [16];
  int           start_log [16];
  vec_t         vecs [8];

  // AES slave answers: the known FIPS-197 AES-192 pair, anything else inverted
  function automatic logic [127:0] slave_result(input logic [127:0] blk);
    if (blk == PT) return CT;
    if (blk == CT) return PT;
    return ~blk;
  endfunction

  // SPI master model: busy for a few cycles after each start, then m_done
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      mdl_cnt = 0;
    end else begin
      m_done <= 1'b0;
      if (m_done) last_done_cyc = cyc;
      if (mdl_cnt > 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0) begin
          m_busy <= 1'b0;
          m_done <= mdl_en;
        end
      end
      if (m_start) begin
        frame_log[start_cnt % 16] = m_data_in;
        start_log[start_cnt % 16] = cyc;
        if (m_data_in != '0) mdl_blk = m_data_in[391:264];
        m_data_out <= {8'h00, slave_result(mdl_blk), 256'h0};
        m_busy     <= 1'b1;
        mdl_cnt    = 3;
        start_cnt  = start_cnt + 1;
        last_start_cyc = cyc;
      end
    end
  end

  task automatic chk_v(input string nm, input logic [391:0] act, input logic [391:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present a request once req_ready is seen; returns the accept cycle
  task automatic issue(input logic dec, input logic [127:0] blk, input logic [255:0] key,
                       input logic [7:0] size, output int acc);
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_i("req_ready_wait", int'(bus.req_ready), 1);
    bus.req_valid    = 1'b1;
    bus.req_decrypt  = dec;
    bus.req_block    = blk;
    bus.req_key      = key;
    bus.req_key_size = size;
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk_i("req_ready_fall", int'(bus.req_ready), 0);
  endtask

  task automatic wait_resp(output int rc);
    int n = 0;
    while (!bus.resp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_i("resp_valid_wait", int'(bus.resp_valid), 1);
    rc = cyc;
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk_i("resp_valid_drop", int'(bus.resp_valid), 0);
    chk_i("req_ready_back", int'(bus.req_ready), 1);
    chk_i("busy_clear", int'(busy), 0);
  endtask

  task automatic run_op(input vec_t v);
    int base, acc, rc;
    base = start_cnt;
    issue(v.dec, v.block, v.key, v.size, acc);
    wait_resp(rc);
    chk_v({v.name, "_block"}, 392'(bus.resp_block), 392'(v.exp_block));
    chk_v({v.name, "_err"}, 392'(bus.resp_err), 392'(v.exp_err));
    chk_i({v.name, "_starts"}, start_cnt - base, v.exp_starts);
    chk_i({v.name, "_busy"}, int'(busy), 1);
    if (v.exp_starts == 0) begin
      chk_i({v.name, "_err_latency"}, rc - acc, 2);
    end else begin
      chk_v({v.name, "_send_frame"}, frame_log[base % 16], {v.block, v.size, v.key});
      chk_i({v.name, "_first_start"}, start_log[base % 16] - acc, 2);
      chk_i({v.name, "_done_to_resp"}, rc - last_done_cyc, 2);
      for (int i = 1; i < v.exp_starts; i++)
        chk_v({v.name, "_poll_frame"}, frame_log[(base + i) % 16], 392'h0);
    end
    handshake();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  acc, rc, base, n;
    bit  stable;

    vecs[0] = '{"enc192", 1'b0, PT, KEY24, 8'd24, CT, 2'b00, 3};
    vecs[1] = '{"dec192", 1'b1, CT, KEY24, 8'd24, PT, 2'b00, 4};
    vecs[2] = '{"size20", 1'b0, PT, KEY24, 8'd20, 128'h0, 2'b01, 0};
    vecs[3] = '{"enc128", 1'b0, 128'h0123456789abcdeffedcba9876543210, KEY16, 8'd16,
                128'hfedcba98765432100123456789abcdef, 2'b00, 3};
    vecs[4] = '{"dec256", 1'b1, 128'hffffffff000000000000000000000000, KEY32, 8'd32,
                128'h00000000ffffffffffffffffffffffff, 2'b00, 4};
    vecs[5] = '{"size0", 1'b1, CT, KEY24, 8'd0, 128'h0, 2'b01, 0};
    vecs[6] = '{"size33", 1'b0, PT, KEY32, 8'd33, 128'h0, 2'b01, 0};
    vecs[7] = '{"size255", 1'b0, PT, KEY32, 8'd255, 128'h0, 2'b01, 0};

    bus.req_valid    = 1'b0;
    bus.req_decrypt  = 1'b0;
    bus.req_block    = '0;
    bus.req_key      = '0;
    bus.req_key_size = '0;
    bus.resp_ready   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_req_ready", int'(bus.req_ready), 0);
    chk_i("rst_resp_valid", int'(bus.resp_valid), 0);
    chk_v("rst_resp_block", 392'(bus.resp_block), 392'h0);
    chk_v("rst_resp_err", 392'(bus.resp_err), 392'h0);
    chk_i("rst_m_start", int'(m_start), 0);
    chk_v("rst_m_data_in", m_data_in, 392'h0);
    chk_i("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    chk_i("idle_req_ready", int'(bus.req_ready), 1);

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Master never completes: watchdog must fire 64 cycles after the start pulse
    mdl_en = 1'b0;
    base = start_cnt;
    issue(1'b0, PT, KEY24, 8'd24, acc);
    wait_resp(rc);
    chk_v("timeout_err", 392'(bus.resp_err), 392'(2'b10));
    chk_i("timeout_cycles", rc - last_start_cyc, 64);
    chk_i("timeout_starts", start_cnt - base, 1);
    handshake();
    mdl_en = 1'b1;

    // Consumer stalls for 10 cycles while another request is waiting
    issue(1'b0, PT, KEY24, 8'd24, acc);
    wait_resp(rc);
    bus.req_valid = 1'b1;
    bus.req_block = 128'h5a5a;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_block !== CT || bus.req_ready !== 1'b0)
        stable = 1'b0;
    end
    chk_i("stall_stable", int'(stable), 1);
    chk_v("stall_block", 392'(bus.resp_block), 392'(CT));
    bus.req_valid = 1'b0;
    handshake();

    // Reset during the second transfer discards the operation
    base = start_cnt;
    issue(1'b0, PT, KEY24, 8'd24, acc);
    n = 0;
    while (start_cnt < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_i("second_xfer_seen", start_cnt - base, 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_i("mid_rst_req_ready", int'(bus.req_ready), 0);
    chk_i("mid_rst_resp_valid", int'(bus.resp_valid), 0);
    chk_v("mid_rst_resp_block", 392'(bus.resp_block), 392'h0);
    chk_v("mid_rst_resp_err", 392'(bus.resp_err), 392'h0);
    chk_i("mid_rst_m_start", int'(m_start), 0);
    chk_v("mid_rst_m_data_in", m_data_in, 392'h0);
    chk_i("mid_rst_busy", int'(busy), 0);
    reset = 1'b0;
    base = start_cnt;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    chk_i("no_stale_resp", int'(stable), 1);
    chk_i("no_stale_starts", start_cnt - base, 0);
    run_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
